// File: rtl/sargantana_icache_ifill_ctrl.sv
// Instruction-cache line-fill controller: issues one L2 request per miss, gathers the
// response beats into a line buffer and installs the line in the victim way.
module sargantana_icache_ifill_ctrl #(
   parameter int unsigned ICACHE_N_WAY     = 4,
   parameter int unsigned ICACHE_TAG_WIDTH = 20,
   parameter int unsigned IDX_BITS_SIZE    = 12,
   parameter int unsigned PADDR_SIZE       = 32,
   parameter int unsigned FILL_BEATS       = 2,
   parameter int unsigned BEAT_WIDTH       = 128,
   localparam int unsigned LINE_OFFSET     = $clog2(FILL_BEATS * BEAT_WIDTH / 8),
   localparam int unsigned SET_BITS        = IDX_BITS_SIZE - LINE_OFFSET,
   localparam int unsigned WAY_BITS        = $clog2(ICACHE_N_WAY),
   localparam int unsigned LINE_WIDTH      = FILL_BEATS * BEAT_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        miss_i,
   input  logic [ICACHE_TAG_WIDTH-1:0] cline_tag_i,
   input  logic [IDX_BITS_SIZE-1:0]    idx_i,
   input  logic [WAY_BITS-1:0]         way_to_replace_i,
   input  logic                        kill_i,
   input  logic                        flush_i,
   output logic                        ifill_req_valid_o,
   input  logic                        ifill_req_ready_i,
   output logic [PADDR_SIZE-1:0]       ifill_req_paddr_o,
   input  logic                        ifill_resp_valid_i,
   input  logic [BEAT_WIDTH-1:0]       ifill_resp_data_i,
   output logic                        line_we_o,
   output logic [WAY_BITS-1:0]         line_way_o,
   output logic [SET_BITS-1:0]         line_set_o,
   output logic [ICACHE_TAG_WIDTH-1:0] line_tag_o,
   output logic [LINE_WIDTH-1:0]       line_data_o,
   output logic                        ifill_process_started_o,
   output logic                        ifill_done_o
);

   localparam int unsigned CntW = (FILL_BEATS > 1) ? $clog2(FILL_BEATS) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StWrite} state_e;

   state_e                      state_q, state_d;
   logic [ICACHE_TAG_WIDTH-1:0] tag_q, tag_d;
   logic [SET_BITS-1:0]         set_q, set_d;
   logic [WAY_BITS-1:0]         way_q, way_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic [LINE_WIDTH-1:0]       buf_q, buf_d;
   logic                        kill_pend_q, kill_pend_d;
   logic                        flush_pend_q, flush_pend_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= StIdle;
         tag_q        <= '0;
         set_q        <= '0;
         way_q        <= '0;
         cnt_q        <= '0;
         buf_q        <= '0;
         kill_pend_q  <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         set_q        <= set_d;
         way_q        <= way_d;
         cnt_q        <= cnt_d;
         buf_q        <= buf_d;
         kill_pend_q  <= kill_pend_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      tag_d             = tag_q;
      set_d             = set_q;
      way_d             = way_q;
      cnt_d             = cnt_q;
      buf_d             = buf_q;
      kill_pend_d       = kill_pend_q;
      flush_pend_d      = flush_pend_q;
      ifill_req_valid_o = 1'b0;
      line_we_o         = 1'b0;
      ifill_done_o      = 1'b0;

      case (state_q)
         StIdle: begin
            if (miss_i && !kill_i && !flush_i) begin
               tag_d   = cline_tag_i;
               set_d   = idx_i[IDX_BITS_SIZE-1:LINE_OFFSET];
               way_d   = way_to_replace_i;
               state_d = StReq;
            end
         end
         StReq: begin
            ifill_req_valid_o = 1'b1;
            // Once L2 has taken the request its beats must be drained, so a late
            // kill/flush is only remembered rather than acted on.
            if (ifill_req_ready_i) begin
               state_d      = StWait;
               cnt_d        = '0;
               kill_pend_d  = kill_i;
               flush_pend_d = flush_i;
            end else if (kill_i || flush_i) begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (kill_i)  kill_pend_d  = 1'b1;
            if (flush_i) flush_pend_d = 1'b1;
            if (ifill_resp_valid_i) begin
               buf_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = ifill_resp_data_i;
               if (cnt_q == CntW'(FILL_BEATS - 1)) state_d = StWrite;
               else                                cnt_d   = cnt_q + CntW'(1);
            end
         end
         StWrite: begin
            // A kill still installs the line; only a flush keeps it out of the array.
            line_we_o    = !(flush_pend_q || flush_i);
            ifill_done_o = !(kill_pend_q || kill_i || flush_pend_q || flush_i);
            state_d      = StIdle;
            cnt_d        = '0;
            kill_pend_d  = 1'b0;
            flush_pend_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ifill_req_paddr_o       = {tag_q, set_q, {LINE_OFFSET{1'b0}}};
   assign line_way_o              = way_q;
   assign line_set_o              = set_q;
   assign line_tag_o              = tag_q;
   assign line_data_o             = buf_q;
   assign ifill_process_started_o = (state_q != StIdle);

endmodule

// File: tb/tb_sargantana_icache_ifill_ctrl.sv
// Directed self-checking bench for the icache line-fill controller.
module tb_sargantana_icache_ifill_ctrl;

   logic         clk_i = 1'b0;
   logic         rstn_i;
   logic         miss_i;
   logic [19:0]  cline_tag_i;
   logic [11:0]  idx_i;
   logic [1:0]   way_to_replace_i;
   logic         kill_i;
   logic         flush_i;
   logic         ifill_req_valid_o;
   logic         ifill_req_ready_i;
   logic [31:0]  ifill_req_paddr_o;
   logic         ifill_resp_valid_i;
   logic [127:0] ifill_resp_data_i;
   logic         line_we_o;
   logic [1:0]   line_way_o;
   logic [6:0]   line_set_o;
   logic [19:0]  line_tag_o;
   logic [255:0] line_data_o;
   logic         ifill_process_started_o;
   logic         ifill_done_o;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [127:0] B11 = {4{32'h11111111}};
   localparam logic [127:0] B22 = {4{32'h22222222}};
   localparam logic [127:0] BA  = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] BB  = 128'hDEADBEEF_CAFEF00D_0BADC0DE_55AA55AA;
   localparam logic [127:0] BX  = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;

   always #5 clk_i = ~clk_i;

   sargantana_icache_ifill_ctrl dut (
      .clk_i                   (clk_i),
      .rstn_i                  (rstn_i),
      .miss_i                  (miss_i),
      .cline_tag_i             (cline_tag_i),
      .idx_i                   (idx_i),
      .way_to_replace_i        (way_to_replace_i),
      .kill_i                  (kill_i),
      .flush_i                 (flush_i),
      .ifill_req_valid_o       (ifill_req_valid_o),
      .ifill_req_ready_i       (ifill_req_ready_i),
      .ifill_req_paddr_o       (ifill_req_paddr_o),
      .ifill_resp_valid_i      (ifill_resp_valid_i),
      .ifill_resp_data_i       (ifill_resp_data_i),
      .line_we_o               (line_we_o),
      .line_way_o              (line_way_o),
      .line_set_o              (line_set_o),
      .line_tag_o              (line_tag_o),
      .line_data_o             (line_data_o),
      .ifill_process_started_o (ifill_process_started_o),
      .ifill_done_o            (ifill_done_o)
   );

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      miss_i = 0; kill_i = 0; flush_i = 0; ifill_req_ready_i = 0;
      ifill_resp_valid_i = 0; ifill_resp_data_i = '0;
   endtask

   task automatic start_miss(input logic [19:0] tag, input logic [11:0] idx,
                             input logic [1:0] way);
      miss_i = 1; cline_tag_i = tag; idx_i = idx; way_to_replace_i = way;
      step();
      miss_i = 0;
   endtask

   task automatic test_reset();
      rstn_i = 0; idle_inputs(); cline_tag_i = '0; idx_i = '0; way_to_replace_i = '0;
      #2;
      if (ifill_req_valid_o !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", ifill_req_valid_o);
      else n_pass++;
      n_total++;
      if (ifill_req_paddr_o !== 32'h0) $display("FAIL reset_paddr: got %h want 0", ifill_req_paddr_o);
      else n_pass++;
      n_total++;
      if ({line_we_o, ifill_done_o, ifill_process_started_o} !== 3'b000)
         $display("FAIL reset_ctrl: got %b want 000", {line_we_o, ifill_done_o, ifill_process_started_o});
      else n_pass++;
      n_total++;
      if ({line_data_o, line_tag_o, line_set_o, line_way_o} !== '0)
         $display("FAIL reset_line: got data %h tag %h want 0", line_data_o, line_tag_o);
      else n_pass++;
      n_total++;
      step(); step();
      rstn_i = 1;
      step();
   endtask

   task automatic test_basic_fill();
      miss_i = 1; cline_tag_i = 20'hABCDE; idx_i = 12'h3A0; way_to_replace_i = 2'd2;
      #1;
      if (ifill_process_started_o !== 1'b0) $display("FAIL basic_idle_c0: got %b want 0", ifill_process_started_o);
      else n_pass++;
      n_total++;
      step();
      miss_i = 0; ifill_req_ready_i = 1;
      #1;
      if (ifill_req_valid_o !== 1'b1) $display("FAIL basic_req_valid: got %b want 1", ifill_req_valid_o);
      else n_pass++;
      n_total++;
      if (ifill_req_paddr_o !== 32'hABCDE3A0) $display("FAIL basic_paddr: got %h want abcde3a0", ifill_req_paddr_o);
      else n_pass++;
      n_total++;
      step();
      ifill_req_ready_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = B11;
      #1;
      if (ifill_req_valid_o !== 1'b0) $display("FAIL basic_req_dropped: got %b want 0", ifill_req_valid_o);
      else n_pass++;
      n_total++;
      step();
      ifill_resp_data_i = B22;
      step();
      ifill_resp_valid_i = 0;
      #1;
      if ({line_we_o, ifill_done_o} !== 2'b11) $display("FAIL basic_write_c4: got %b want 11", {line_we_o, ifill_done_o});
      else n_pass++;
      n_total++;
      if ({line_way_o, line_set_o, line_tag_o} !== {2'd2, 7'h1D, 20'hABCDE})
         $display("FAIL basic_way_set_tag: got %h/%h/%h want 2/1d/abcde", line_way_o, line_set_o, line_tag_o);
      else n_pass++;
      n_total++;
      if (line_data_o !== {B22, B11}) $display("FAIL basic_data: got %h want %h", line_data_o, {B22, B11});
      else n_pass++;
      n_total++;
      step();
      #1;
      if ({line_we_o, ifill_done_o, ifill_process_started_o} !== 3'b000)
         $display("FAIL basic_after_write: got %b want 000", {line_we_o, ifill_done_o, ifill_process_started_o});
      else n_pass++;
      n_total++;
   endtask

   task automatic test_ready_stall();
      start_miss(20'h12345, 12'h045, 2'd1);
      // Stray beats during REQ must not land in the buffer.
      for (int c = 0; c < 5; c++) begin
         ifill_resp_valid_i = 1; ifill_resp_data_i = BX;
         #1;
         if (ifill_req_valid_o !== 1'b1 || ifill_req_paddr_o !== 32'h12345040)
            $display("FAIL stall_req_cycle%0d: got %b/%h want 1/12345040", c, ifill_req_valid_o, ifill_req_paddr_o);
         else n_pass++;
         n_total++;
         step();
      end
      ifill_resp_valid_i = 0; ifill_req_ready_i = 1;
      #1;
      if (ifill_req_valid_o !== 1'b1 || ifill_req_paddr_o !== 32'h12345040)
         $display("FAIL stall_req_hs: got %b/%h want 1/12345040", ifill_req_valid_o, ifill_req_paddr_o);
      else n_pass++;
      n_total++;
      step();
      ifill_req_ready_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = BA;
      step();
      ifill_resp_valid_i = 0; ifill_resp_data_i = BX;
      #1;
      if (line_we_o !== 1'b0) $display("FAIL stall_gap_no_write: got %b want 0", line_we_o);
      else n_pass++;
      n_total++;
      step();
      ifill_resp_valid_i = 1; ifill_resp_data_i = BB;
      step();
      ifill_resp_valid_i = 0;
      #1;
      if ({line_we_o, ifill_done_o} !== 2'b11) $display("FAIL stall_write: got %b want 11", {line_we_o, ifill_done_o});
      else n_pass++;
      n_total++;
      if (line_data_o !== {BB, BA}) $display("FAIL stall_data: got %h want %h", line_data_o, {BB, BA});
      else n_pass++;
      n_total++;
      step();
   endtask

   task automatic test_kill_req();
      start_miss(20'h55555, 12'h100, 2'd0);
      kill_i = 1;
      step();
      kill_i = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if ({ifill_process_started_o, ifill_req_valid_o, line_we_o, ifill_done_o} !== 4'b0000)
            $display("FAIL killreq_idle%0d: got %b want 0000", c,
                     {ifill_process_started_o, ifill_req_valid_o, line_we_o, ifill_done_o});
         else n_pass++;
         n_total++;
         step();
      end
      start_miss(20'h00F0F, 12'hFFF, 2'd3);
      ifill_req_ready_i = 1;
      #1;
      if (ifill_req_paddr_o !== 32'h00F0FFE0) $display("FAIL killreq_next_paddr: got %h want 00f0ffe0", ifill_req_paddr_o);
      else n_pass++;
      n_total++;
      step();
      ifill_req_ready_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = BB;
      step();
      ifill_resp_data_i = BA;
      step();
      ifill_resp_valid_i = 0;
      #1;
      if ({line_we_o, ifill_done_o, line_way_o, line_set_o} !== {2'b11, 2'd3, 7'h7F})
         $display("FAIL killreq_next_write: got %b/%h/%h want 11/3/7f", {line_we_o, ifill_done_o}, line_way_o, line_set_o);
      else n_pass++;
      n_total++;
      step();
   endtask

   task automatic test_kill_wait();
      start_miss(20'h0AAAA, 12'h020, 2'd1);
      ifill_req_ready_i = 1;
      step();
      ifill_req_ready_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = B22; kill_i = 1;
      step();
      kill_i = 0; ifill_resp_data_i = B11;
      #1;
      if (ifill_process_started_o !== 1'b1) $display("FAIL killwait_drain: got %b want 1", ifill_process_started_o);
      else n_pass++;
      n_total++;
      step();
      ifill_resp_valid_i = 0;
      #1;
      if ({line_we_o, ifill_done_o} !== 2'b10) $display("FAIL killwait_write: got %b want 10", {line_we_o, ifill_done_o});
      else n_pass++;
      n_total++;
      if (line_data_o !== {B11, B22}) $display("FAIL killwait_data: got %h want %h", line_data_o, {B11, B22});
      else n_pass++;
      n_total++;
      step();
   endtask

   task automatic test_flush_write();
      start_miss(20'h13579, 12'h7E0, 2'd2);
      ifill_req_ready_i = 1;
      step();
      ifill_req_ready_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = BA;
      step();
      ifill_resp_data_i = B11;
      step();
      ifill_resp_valid_i = 0; flush_i = 1;
      #1;
      if ({line_we_o, ifill_done_o} !== 2'b00) $display("FAIL flush_write: got %b want 00", {line_we_o, ifill_done_o});
      else n_pass++;
      n_total++;
      step();
      flush_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = BX;
      #1;
      if (ifill_process_started_o !== 1'b0) $display("FAIL flush_idle: got %b want 0", ifill_process_started_o);
      else n_pass++;
      n_total++;
      step();
      ifill_resp_valid_i = 0;
      #1;
      if ({ifill_process_started_o, ifill_req_valid_o, line_we_o} !== 3'b000)
         $display("FAIL stray_state: got %b want 000", {ifill_process_started_o, ifill_req_valid_o, line_we_o});
      else n_pass++;
      n_total++;
      if (line_data_o !== {B11, BA}) $display("FAIL stray_data: got %h want %h", line_data_o, {B11, BA});
      else n_pass++;
      n_total++;
      step();
   endtask

   task automatic test_reset_mid_fill();
      start_miss(20'hFEDCB, 12'h0C0, 2'd3);
      ifill_req_ready_i = 1;
      step();
      ifill_req_ready_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = BB;
      step();
      ifill_resp_valid_i = 0;
      rstn_i = 0;
      #1;
      if ({ifill_process_started_o, ifill_req_valid_o, line_we_o, ifill_done_o} !== 4'b0000)
         $display("FAIL rstmid_ctrl: got %b want 0000",
                  {ifill_process_started_o, ifill_req_valid_o, line_we_o, ifill_done_o});
      else n_pass++;
      n_total++;
      if ({line_data_o, ifill_req_paddr_o, line_way_o} !== '0)
         $display("FAIL rstmid_regs: got data %h paddr %h want 0", line_data_o, ifill_req_paddr_o);
      else n_pass++;
      n_total++;
      step();
      rstn_i = 1; ifill_resp_valid_i = 1; ifill_resp_data_i = BA;
      step();
      ifill_resp_valid_i = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if ({ifill_process_started_o, line_we_o, ifill_done_o} !== 3'b000 || line_data_o !== '0)
            $display("FAIL rstmid_after%0d: got %b data %h want 000 data 0", c,
                     {ifill_process_started_o, line_we_o, ifill_done_o}, line_data_o);
         else n_pass++;
         n_total++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_ready_stall();
      test_kill_req();
      test_kill_wait();
      test_flush_write();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sargantana_icache_ifill_ctrl.md
# sargantana_icache_ifill_ctrl

Line-fill controller for the Sargantana instruction cache, directly downstream of the icache pipeline register stage. It consumes the registered miss information (tag, index, victim way, kill, flush), issues one line-fill request to L2 and collects the response beats. It then writes the assembled line into the selected way and signals completion back to the icache control logic.

## Interface
- ICACHE_N_WAY, 4, number of ways
- ICACHE_TAG_WIDTH, 20, physical tag width
- IDX_BITS_SIZE, 12, untranslated index width; ICACHE_TAG_WIDTH+IDX_BITS_SIZE = PADDR_SIZE
- PADDR_SIZE, 32, physical address width
- FILL_BEATS, 2, response beats per line (power of 2, ≥1)
- BEAT_WIDTH, 128, bits per beat; LINE_OFFSET = $clog2(FILL_BEATS*BEAT_WIDTH/8), SET_BITS = IDX_BITS_SIZE-LINE_OFFSET

Ports:
- clk_i  in  1  clock, all state on rising edge
- rstn_i  in  1  asynchronous active-low reset
- miss_i  in  1  registered request missed in all ways (valid, no MMU exception)
- cline_tag_i  in  ICACHE_TAG_WIDTH  physical tag of missing line
- idx_i  in  IDX_BITS_SIZE  index of missing request
- way_to_replace_i  in  $clog2(ICACHE_N_WAY)  victim way
- kill_i  in  1  frontend kills the outstanding fetch
- flush_i  in  1  icache flush
- ifill_req_valid_o  out  1  fill request valid
- ifill_req_ready_i  in  1  L2 accepts request
- ifill_req_paddr_o  out  PADDR_SIZE  line-aligned physical address
- ifill_resp_valid_i  in  1  response beat valid
- ifill_resp_data_i  in  BEAT_WIDTH  response beat data
- line_we_o  out  1  one-cycle cache line write enable
- line_way_o  out  $clog2(ICACHE_N_WAY)  way written
- line_set_o  out  SET_BITS  set written
- line_tag_o  out  ICACHE_TAG_WIDTH  tag written
- line_data_o  out  FILL_BEATS*BEAT_WIDTH  line data, beat 0 in LSBs
- ifill_process_started_o  out  1  controller not idle
- ifill_done_o  out  1  one-cycle pulse, fill delivered to a live request

## Operation
- States IDLE, REQ, WAIT, WRITE. Latched: tag, set = idx_i[IDX_BITS_SIZE-1:LINE_OFFSET], way, beat counter, line buffer, kill_pend, flush_pend.
- IDLE: miss_i & !kill_i & !flush_i -> latch tag/set/way, go REQ. Otherwise stay. miss_i outside IDLE ignored.
- REQ: ifill_req_valid_o=1, paddr = {tag, set, LINE_OFFSET'b0}, stable until handshake. Handshake (valid&ready) -> WAIT, counter=0. kill_i or flush_i without handshake that cycle -> IDLE, request withdrawn. Kill/flush in the handshake cycle -> go WAIT, set kill_pend/flush_pend.
- WAIT: each ifill_resp_valid_i stores beat into buffer[counter], counter++. Last beat (counter==FILL_BEATS-1) -> WRITE. kill_i/flush_i set kill_pend/flush_pend. Beats always fully drained.
- WRITE (one cycle): line_we_o = !(flush_pend|flush_i). ifill_done_o = !(kill_pend|kill_i|flush_pend|flush_i). Always -> IDLE, flags and counter cleared. Kill only suppresses done; line is still installed. Flush suppresses both.
- ifill_resp_valid_i outside WAIT ignored; no buffer update.
- line_way_o/line_set_o/line_tag_o/line_data_o reflect latched values continuously; meaningful only with line_we_o.
- ifill_process_started_o = (state != IDLE).

## Timing
- Reset: state IDLE; all outputs 0; buffer, counter, flags, latched tag/set/way 0. Reset mid-fill abandons the transaction without a write.
- Miss sampled cycle 0 -> req valid cycle 1. Ready at cycle 1 -> beats accepted from cycle 2. Last beat at cycle n -> line_we_o/ifill_done_o at n+1 -> IDLE at n+2. New miss accepted at n+2.
- Minimum miss-to-write with FILL_BEATS=2: 4 cycles.
- Response beats may arrive the cycle after handshake with arbitrary gaps. No back-pressure on responses.

## Test plan
- Basic fill: tag=20'hABCDE, idx=12'h3A0, way=2, ready immediately, beats 128'h11.., 128'h22.. back-to-back -> paddr 32'hABCDE3A0, line_we_o cycle 4, set 7'h1D, way 2, data {22..,11..}, ifill_done_o one pulse.
- Ready held low 5 cycles -> req valid and paddr stable all 6 cycles, no beats captured early, write 1 cycle after last beat.
- kill_i in REQ before ready -> IDLE next cycle, no write, no done; following miss starts normally.
- kill_i during WAIT -> both beats drained, line_we_o=1, ifill_done_o=0.
- flush_i in WRITE cycle -> line_we_o=0, ifill_done_o=0, IDLE next cycle; stray ifill_resp_valid_i in IDLE -> no state change.
- rstn_i low during WAIT -> all outputs 0 immediately, IDLE, no write after release.
